// File: rtl/err_eval_pkg.sv
// Shared widths and FSM encoding for the approximate-adder error statistics engine.
package err_eval_pkg;

    localparam int IN_W   = 8;
    localparam int OUT_W  = IN_W + 1;
    localparam int CNT_W  = 17;
    localparam int ACC_W  = OUT_W + CNT_W;
    localparam int SACC_W = ACC_W + 1;
    localparam int DIFF_W = OUT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/err_calc.sv
// Second pipeline stage: recompute the exact sum and register signed and absolute error.
module err_calc #(
    parameter int IN_W  = err_eval_pkg::IN_W,
    parameter int OUT_W = err_eval_pkg::OUT_W,
    parameter int CNT_W = err_eval_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [OUT_W-1:0] approx,
    input  logic [CNT_W-1:0] idx_in,
    output logic             out_valid,
    output logic [OUT_W:0]   diff,
    output logic [OUT_W-1:0] abs_err,
    output logic [CNT_W-1:0] idx_out
);

    logic             valid_q, valid_d;
    logic [OUT_W:0]   diff_q, diff_d;
    logic [OUT_W-1:0] abs_q, abs_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] exact;

    always_comb begin
        exact   = OUT_W'(a) + OUT_W'(b);
        valid_d = in_valid;
        diff_d  = {1'b0, approx} - {1'b0, exact};
        // |diff| always fits OUT_W bits, so the modular subtraction in the right order is exact
        abs_d   = diff_d[OUT_W] ? (exact - approx) : (approx - exact);
        idx_d   = idx_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            abs_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            diff_q  <= diff_d;
            abs_q   <= abs_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign diff      = diff_q;
    assign abs_err   = abs_q;
    assign idx_out   = idx_q;

endmodule

// File: rtl/err_stats_accum.sv
// Streaming error-statistics engine for an IN_W+IN_W->OUT_W approximate adder:
// input capture, run-control FSM and metric accumulators around the err_calc stage.
module err_stats_accum #(
    parameter int IN_W  = err_eval_pkg::IN_W,
    parameter int OUT_W = err_eval_pkg::OUT_W,
    parameter int CNT_W = err_eval_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_samples,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        a,
    input  logic [IN_W-1:0]        b,
    input  logic [OUT_W-1:0]       approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [OUT_W+CNT_W-1:0] sum_abs_err,
    output logic [OUT_W+CNT_W:0]   sum_signed_err,
    output logic [OUT_W-1:0]       max_err,
    output logic [CNT_W-1:0]       max_idx
);

    localparam int ACC_W  = OUT_W + CNT_W;
    localparam int SACC_W = ACC_W + 1;
    localparam int DIFF_W = OUT_W + 1;

    err_eval_pkg::state_t state_q, state_d;

    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;

    logic              s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]   s1_a_q, s1_a_d;
    logic [IN_W-1:0]   s1_b_q, s1_b_d;
    logic [OUT_W-1:0]  s1_approx_q, s1_approx_d;
    logic [CNT_W-1:0]  s1_idx_q, s1_idx_d;

    logic              s2_valid;
    logic [DIFF_W-1:0] s2_diff;
    logic [OUT_W-1:0]  s2_abs;
    logic [CNT_W-1:0]  s2_idx;

    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0]  sum_abs_q, sum_abs_d;
    logic [SACC_W-1:0] sum_sgn_q, sum_sgn_d;
    logic [OUT_W-1:0]  max_err_q, max_err_d;
    logic [CNT_W-1:0]  max_idx_q, max_idx_d;

    logic xfer;

    assign in_ready = (state_q == err_eval_pkg::RUN) && (acc_cnt_q < n_q);
    assign xfer     = in_valid && in_ready;

    err_calc #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) u_err_calc (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .approx   (s1_approx_q),
        .idx_in   (s1_idx_q),
        .out_valid(s2_valid),
        .diff     (s2_diff),
        .abs_err  (s2_abs),
        .idx_out  (s2_idx)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        acc_cnt_d    = acc_cnt_q;
        s1_valid_d   = xfer;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_approx_d  = s1_approx_q;
        s1_idx_d     = s1_idx_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_abs_d    = sum_abs_q;
        sum_sgn_d    = sum_sgn_q;
        max_err_d    = max_err_q;
        max_idx_d    = max_idx_q;

        if (xfer) begin
            s1_a_d      = a;
            s1_b_d      = b;
            s1_approx_d = approx_sum;
            s1_idx_d    = acc_cnt_q;
        end

        if (s2_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (s2_diff != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            sum_abs_d = sum_abs_q + ACC_W'(s2_abs);
            sum_sgn_d = sum_sgn_q + {{(SACC_W-DIFF_W){s2_diff[DIFF_W-1]}}, s2_diff};
            // strict compare so a tie keeps the earliest index
            if (s2_abs > max_err_q) begin
                max_err_d = s2_abs;
                max_idx_d = s2_idx;
            end
        end

        unique case (state_q)
            err_eval_pkg::IDLE, err_eval_pkg::DONE: begin
                if (start) begin
                    n_d          = n_samples;
                    acc_cnt_d    = '0;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                    sum_abs_d    = '0;
                    sum_sgn_d    = '0;
                    max_err_d    = '0;
                    max_idx_d    = '0;
                    state_d      = (n_samples == '0) ? err_eval_pkg::DONE : err_eval_pkg::RUN;
                end
            end
            err_eval_pkg::RUN: begin
                if (xfer) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_d == n_q) begin
                        state_d = err_eval_pkg::DRAIN;
                    end
                end
            end
            err_eval_pkg::DRAIN: begin
                if (!s1_valid_q && !s2_valid) begin
                    state_d = err_eval_pkg::DONE;
                end
            end
            default: state_d = err_eval_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= err_eval_pkg::IDLE;
            n_q          <= '0;
            acc_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_approx_q  <= '0;
            s1_idx_q     <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            sum_sgn_q    <= '0;
            max_err_q    <= '0;
            max_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            acc_cnt_q    <= acc_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_approx_q  <= s1_approx_d;
            s1_idx_q     <= s1_idx_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_abs_q    <= sum_abs_d;
            sum_sgn_q    <= sum_sgn_d;
            max_err_q    <= max_err_d;
            max_idx_q    <= max_idx_d;
        end
    end

    assign busy           = (state_q == err_eval_pkg::RUN) || (state_q == err_eval_pkg::DRAIN);
    assign done           = (state_q == err_eval_pkg::DONE);
    assign sample_cnt     = sample_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign sum_abs_err    = sum_abs_q;
    assign sum_signed_err = sum_sgn_q;
    assign max_err        = max_err_q;
    assign max_idx        = max_idx_q;

endmodule

// File: tb/tb_err_stats_accum.sv
// Randomised self-checking bench for err_stats_accum against an arithmetic error model.
module tb_err_stats_accum;

    localparam int IN_W  = 8;
    localparam int OUT_W = 9;
    localparam int CNT_W = 17;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [CNT_W-1:0]       n_samples = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [IN_W-1:0]        a = '0;
    logic [IN_W-1:0]        b = '0;
    logic [OUT_W-1:0]       approx_sum = '0;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       sample_cnt;
    logic [CNT_W-1:0]       err_cnt;
    logic [OUT_W+CNT_W-1:0] sum_abs_err;
    logic [OUT_W+CNT_W:0]   sum_signed_err;
    logic [OUT_W-1:0]       max_err;
    logic [CNT_W-1:0]       max_idx;

    err_stats_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_abs_err(sum_abs_err), .sum_signed_err(sum_signed_err),
        .max_err(max_err), .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int q_a[$];
    int q_b[$];
    int q_s[$];

    longint exp_cnt, exp_err, exp_abs, exp_sgn, exp_max, exp_idx;
    logic   done_after_start, busy_after_start, rdy_after_last;
    int     lat_done;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        q_a.delete();
        q_b.delete();
        q_s.delete();
    endtask

    task automatic push(input int sa, input int sb, input int ss);
        q_a.push_back(sa);
        q_b.push_back(sb);
        q_s.push_back(ss);
    endtask

    // Reference: error of each sample is approx minus the true integer sum.
    task automatic model;
        exp_cnt = 0; exp_err = 0; exp_abs = 0; exp_sgn = 0; exp_max = 0; exp_idx = 0;
        for (int i = 0; i < q_a.size(); i++) begin
            longint e, m;
            e = longint'(q_s[i]) - longint'(q_a[i] + q_b[i]);
            m = (e < 0) ? -e : e;
            exp_cnt++;
            if (e != 0) exp_err++;
            exp_abs += m;
            exp_sgn += e;
            if (m > exp_max) begin
                exp_max = m;
                exp_idx = i;
            end
        end
    endtask

    // Drives a start pulse then every queued sample; poke_start raises start mid-run.
    task automatic exec_run(input int n, input int gap_min, input int gap_max,
                            input bit poke_start, input bit wait_done);
        start = 1'b1;
        n_samples = CNT_W'(n);
        tick;
        start = 1'b0;
        done_after_start = done;
        busy_after_start = busy;
        for (int i = 0; i < q_a.size(); i++) begin
            int g, w;
            g = $urandom_range(gap_max, gap_min);
            repeat (g) tick;
            in_valid = 1'b1;
            a = IN_W'(q_a[i]);
            b = IN_W'(q_b[i]);
            approx_sum = OUT_W'(q_s[i]);
            if (poke_start && (i % 9000 == 5)) begin
                start = 1'b1;
                n_samples = CNT_W'(3);
            end
            w = 0;
            while (!in_ready && w < 50) begin
                tick;
                w++;
            end
            if (w >= 50) begin
                checks++;
                $display("FAIL in_ready_timeout sample %0d: in_ready=%b, required 1", i, in_ready);
            end
            tick;
            start = 1'b0;
            in_valid = 1'b0;
        end
        rdy_after_last = in_ready;
        lat_done = 0;
        if (wait_done) begin
            while (!done && lat_done < 20) begin
                tick;
                lat_done++;
            end
            if (!done) begin
                checks++;
                $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat_done);
            end
        end
        $display("run n=%0d samples=%0d sample_cnt=%0d err_cnt=%0d sum_abs=%0d sum_sgn=%0d max_err=%0d max_idx=%0d",
                 n, q_a.size(), sample_cnt, err_cnt, sum_abs_err, $signed(sum_signed_err), max_err, max_idx);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        checks++; if ({in_ready, busy, done} !== 3'b000) $display("FAIL reset_ctrl: ready/busy/done=%b required 000", {in_ready, busy, done}); else passes++;
        checks++; if ({sample_cnt, err_cnt, sum_abs_err, sum_signed_err, max_err, max_idx} !== '0) $display("FAIL reset_stats: cnt=%0d err=%0d abs=%0d max=%0d required all 0", sample_cnt, err_cnt, sum_abs_err, max_err); else passes++;
        clear_q;
        exec_run(0, 0, 0, 0, 1);
        checks++; if (done_after_start !== 1'b1) $display("FAIL zero_n_done: done=%b one cycle after start, required 1", done_after_start); else passes++;
        checks++; if ({sample_cnt, err_cnt, sum_abs_err, sum_signed_err, max_err, max_idx} !== '0) $display("FAIL zero_n_stats: cnt=%0d abs=%0d required all 0", sample_cnt, sum_abs_err); else passes++;
    endtask

    task automatic test_single;
        clear_q;
        push(3, 4, 0);
        model;
        exec_run(1, 0, 0, 0, 1);
        checks++; if (done_after_start !== 1'b0 || busy_after_start !== 1'b1) $display("FAIL single_start: done=%b busy=%b after start, required 0/1", done_after_start, busy_after_start); else passes++;
        checks++; if (sample_cnt !== 17'd1) $display("FAIL single_cnt: got %0d required 1", sample_cnt); else passes++;
        checks++; if (err_cnt !== 17'd1) $display("FAIL single_err: got %0d required 1", err_cnt); else passes++;
        checks++; if (sum_abs_err !== 26'd7) $display("FAIL single_abs: got %0d required 7", sum_abs_err); else passes++;
        checks++; if (sum_signed_err !== -27'sd7) $display("FAIL single_sgn: got %0d required -7", $signed(sum_signed_err)); else passes++;
        checks++; if (max_err !== 9'd7 || max_idx !== 17'd0) $display("FAIL single_max: got %0d@%0d required 7@0", max_err, max_idx); else passes++;
    endtask

    task automatic test_mixed_stall;
        clear_q;
        push(10, 5, 15);
        push(8, 8, 20);
        push(1, 1, 2);
        model;
        exec_run(3, 2, 2, 0, 1);
        checks++; if (err_cnt !== 17'(exp_err) || exp_err != 1) $display("FAIL mixed_err: got %0d required 1", err_cnt); else passes++;
        checks++; if (sum_abs_err !== 26'(exp_abs)) $display("FAIL mixed_abs: got %0d required %0d", sum_abs_err, exp_abs); else passes++;
        checks++; if (sum_signed_err !== 27'(exp_sgn)) $display("FAIL mixed_sgn: got %0d required %0d", $signed(sum_signed_err), exp_sgn); else passes++;
        checks++; if (max_err !== 9'(exp_max) || max_idx !== 17'(exp_idx)) $display("FAIL mixed_max: got %0d@%0d required %0d@%0d", max_err, max_idx, exp_max, exp_idx); else passes++;
        checks++; if (rdy_after_last !== 1'b0) $display("FAIL mixed_ready: in_ready=%b after last transfer, required 0", rdy_after_last); else passes++;
        checks++; if (lat_done != 3) $display("FAIL mixed_done_lat: done after %0d cycles, required 3", lat_done); else passes++;
        checks++; if (sample_cnt !== 17'd3) $display("FAIL mixed_cnt: got %0d required 3", sample_cnt); else passes++;
    endtask

    task automatic test_max_tie;
        clear_q;
        push(0, 0, 16);
        push(16, 16, 16);
        model;
        exec_run(2, 0, 1, 0, 1);
        checks++; if (max_err !== 9'd16) $display("FAIL tie_max: got %0d required 16", max_err); else passes++;
        checks++; if (max_idx !== 17'd0) $display("FAIL tie_idx: got %0d required 0", max_idx); else passes++;
        checks++; if (sum_signed_err !== 27'(exp_sgn)) $display("FAIL tie_sgn: got %0d required %0d", $signed(sum_signed_err), exp_sgn); else passes++;
    endtask

    task automatic test_random;
        clear_q;
        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            push(ra, rb, ($urandom_range(2, 0) == 0) ? (ra + rb) : int'($urandom_range(511, 0)));
        end
        model;
        exec_run(40, 0, 1, 0, 1);
        checks++; if (sample_cnt !== 17'(exp_cnt)) $display("FAIL rand_cnt: got %0d required %0d", sample_cnt, exp_cnt); else passes++;
        checks++; if (err_cnt !== 17'(exp_err)) $display("FAIL rand_err: got %0d required %0d", err_cnt, exp_err); else passes++;
        checks++; if (sum_abs_err !== 26'(exp_abs)) $display("FAIL rand_abs: got %0d required %0d", sum_abs_err, exp_abs); else passes++;
        checks++; if (sum_signed_err !== 27'(exp_sgn)) $display("FAIL rand_sgn: got %0d required %0d", $signed(sum_signed_err), exp_sgn); else passes++;
        checks++; if (max_err !== 9'(exp_max) || max_idx !== 17'(exp_idx)) $display("FAIL rand_max: got %0d@%0d required %0d@%0d", max_err, max_idx, exp_max, exp_idx); else passes++;
    endtask

    task automatic test_exhaustive;
        clear_q;
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                push(ia, ib, (ia + ib) & 'h1F0);
            end
        end
        model;
        exec_run(65536, 0, 0, 1, 1);
        checks++; if (sample_cnt !== 17'd65536) $display("FAIL exh_cnt: got %0d required 65536", sample_cnt); else passes++;
        checks++; if (err_cnt !== 17'(exp_err)) $display("FAIL exh_err: got %0d required %0d", err_cnt, exp_err); else passes++;
        checks++; if (sum_abs_err !== 26'(exp_abs)) $display("FAIL exh_abs: got %0d required %0d", sum_abs_err, exp_abs); else passes++;
        checks++; if (max_err !== 9'd15 || max_idx !== 17'(exp_idx)) $display("FAIL exh_max: got %0d@%0d required 15@%0d", max_err, max_idx, exp_idx); else passes++;
        checks++; if (sum_signed_err !== 27'(exp_sgn)) $display("FAIL exh_sgn: got %0d required %0d", $signed(sum_signed_err), exp_sgn); else passes++;
    endtask

    task automatic test_abort;
        clear_q;
        for (int i = 0; i < 5; i++) push(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), int'($urandom_range(511, 0)));
        exec_run(10, 0, 0, 0, 0);
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_pre: busy=%b mid-run, required 1", busy); else passes++;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        checks++; if ({busy, done, in_ready} !== 3'b000 || sample_cnt !== '0 || sum_abs_err !== '0) $display("FAIL abort_reset: busy/done/rdy=%b cnt=%0d abs=%0d required 000/0/0", {busy, done, in_ready}, sample_cnt, sum_abs_err); else passes++;
        clear_q;
        push(200, 100, 0);
        model;
        exec_run(1, 0, 0, 0, 1);
        checks++; if (sample_cnt !== 17'd1 || err_cnt !== 17'd1) $display("FAIL abort_cnt: cnt=%0d err=%0d required 1/1", sample_cnt, err_cnt); else passes++;
        checks++; if (sum_abs_err !== 26'(exp_abs) || sum_signed_err !== 27'(exp_sgn)) $display("FAIL abort_sums: abs=%0d sgn=%0d required %0d/%0d", sum_abs_err, $signed(sum_signed_err), exp_abs, exp_sgn); else passes++;
        checks++; if (max_err !== 9'(exp_max) || max_idx !== 17'd0) $display("FAIL abort_max: got %0d@%0d required %0d@0", max_err, max_idx, exp_max); else passes++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_mixed_stall;
        test_max_tie;
        test_random;
        test_exhaustive;
        test_abort;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
